// File: rtl/bus_rr_arbiter_if.sv
// Bus bundle for bus_rr_arbiter: NrHosts Ibex-style host ports plus one
// downstream device port. The slave modport is the arbiter's view; the
// master modport is the view of whatever drives the hosts and the device.
interface bus_rr_arbiter_if #(
  parameter int NrHosts      = 2,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  localparam int BeWidth = DataWidth / 8;

  // Host side
  logic [NrHosts-1:0]      host_req_i;
  logic [NrHosts-1:0]      host_gnt_o;
  logic [AddressWidth-1:0] host_addr_i  [NrHosts];
  logic [NrHosts-1:0]      host_we_i;
  logic [BeWidth-1:0]      host_be_i    [NrHosts];
  logic [DataWidth-1:0]    host_wdata_i [NrHosts];
  logic [NrHosts-1:0]      host_rvalid_o;
  logic [DataWidth-1:0]    host_rdata_o [NrHosts];
  logic [NrHosts-1:0]      host_err_o;

  // Device side
  logic                    dev_req_o;
  logic                    dev_gnt_i;
  logic [AddressWidth-1:0] dev_addr_o;
  logic                    dev_we_o;
  logic [BeWidth-1:0]      dev_be_o;
  logic [DataWidth-1:0]    dev_wdata_o;
  logic                    dev_rvalid_i;
  logic [DataWidth-1:0]    dev_rdata_i;
  logic                    dev_err_i;

  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
    input  dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
    output dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one downstream bus port among NrHosts hosts.
// One outstanding transaction at a time; a pending ungranted selection is
// locked until the device grants it; a response timeout returns an error
// to the owner so a silent device cannot hang the hosts.
module bus_rr_arbiter #(
  parameter int NrHosts       = 2,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 255
) (
  input logic              clk_i,
  input logic              rst_ni,
  bus_rr_arbiter_if.slave  bus
);
  localparam int PtrWidth = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int TmoWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int TmoLast  = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
  localparam logic [TmoWidth-1:0] TmoLastVal = TmoWidth'(TmoLast);
  localparam logic [TmoWidth-1:0] TmoMaxVal  = '1;

  typedef enum logic {IDLE, WAIT_RESP} state_t;

  state_t                state_reg, state_next;
  logic [PtrWidth-1:0]   rr_ptr_reg, rr_ptr_next;
  logic                  lock_valid_reg, lock_valid_next;
  logic [PtrWidth-1:0]   lock_idx_reg, lock_idx_next;
  logic [PtrWidth-1:0]   owner_reg, owner_next;
  logic [TmoWidth-1:0]   tmo_cnt_reg, tmo_cnt_next;

  logic                  any_req;
  logic [PtrWidth-1:0]   winner;
  logic [PtrWidth-1:0]   scan_idx;
  logic [PtrWidth-1:0]   sel;
  logic                  req_active;
  logic                  grant_fire;
  logic                  tmo_hit;
  logic                  resp_fire;
  logic                  resp_err;
  logic [DataWidth-1:0]  resp_rdata;

  // Round-robin scan starting at rr_ptr; first requester found wins
  always_comb begin
    any_req  = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int i = 0; i < NrHosts; i++) begin
      scan_idx = PtrWidth'((int'(rr_ptr_reg) + i) % NrHosts);
      if (!any_req && bus.host_req_i[scan_idx]) begin
        any_req = 1'b1;
        winner  = scan_idx;
      end
    end
  end

  // Selection: a locked choice wins over a fresh arbitration result
  always_comb begin
    sel        = lock_valid_reg ? lock_idx_reg : winner;
    req_active = (state_reg == IDLE) && (lock_valid_reg || any_req);
    grant_fire = req_active && bus.dev_gnt_i;
  end

  // Response path: real response has priority over a timeout in the same cycle
  always_comb begin
    tmo_hit    = (TimeoutCycles != 0) && (tmo_cnt_reg == TmoLastVal);
    resp_fire  = (state_reg == WAIT_RESP) && (bus.dev_rvalid_i || tmo_hit);
    resp_err   = bus.dev_rvalid_i ? bus.dev_err_i : 1'b1;
    resp_rdata = bus.dev_rvalid_i ? bus.dev_rdata_i : '0;
  end

  // Forward the selected host's request fields; all zero when nothing is selected
  always_comb begin
    bus.dev_req_o   = req_active;
    bus.dev_addr_o  = '0;
    bus.dev_we_o    = 1'b0;
    bus.dev_be_o    = '0;
    bus.dev_wdata_o = '0;
    if (req_active) begin
      bus.dev_addr_o  = bus.host_addr_i[sel];
      bus.dev_we_o    = bus.host_we_i[sel];
      bus.dev_be_o    = bus.host_be_i[sel];
      bus.dev_wdata_o = bus.host_wdata_i[sel];
    end
  end

  // Per-host grant and response demultiplexing
  for (genvar gi = 0; gi < NrHosts; gi++) begin : g_host
    logic is_sel;
    logic is_owner;
    assign is_sel   = (sel == PtrWidth'(gi));
    assign is_owner = resp_fire && (owner_reg == PtrWidth'(gi));
    assign bus.host_gnt_o[gi]    = grant_fire && is_sel;
    assign bus.host_rvalid_o[gi] = is_owner;
    assign bus.host_err_o[gi]    = is_owner && resp_err;
    assign bus.host_rdata_o[gi]  = is_owner ? resp_rdata : '0;
  end

  // Next-state logic for the FSM, pointer, lock, owner and timeout counter
  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    lock_valid_next = lock_valid_reg;
    lock_idx_next   = lock_idx_reg;
    owner_next      = owner_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (grant_fire) begin
          state_next      = WAIT_RESP;
          owner_next      = sel;
          rr_ptr_next     = PtrWidth'((int'(sel) + 1) % NrHosts);
          lock_valid_next = 1'b0;
          tmo_cnt_next    = '0;
        end else if (req_active) begin
          // Freeze the choice so later requesters cannot change the address
          // the device is already looking at.
          lock_valid_next = 1'b1;
          lock_idx_next   = sel;
        end
      end
      WAIT_RESP: begin
        if (tmo_cnt_reg != TmoMaxVal) begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
        if (resp_fire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      lock_valid_reg <= 1'b0;
      lock_idx_reg   <= '0;
      owner_reg      <= '0;
      tmo_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      lock_valid_reg <= lock_valid_next;
      lock_idx_reg   <= lock_idx_next;
      owner_reg      <= owner_next;
      tmo_cnt_reg    <= tmo_cnt_next;
    end
  end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter (2 hosts, TimeoutCycles=4).
// Each table row drives one cycle of inputs and carries the outputs expected
// in that cycle; rows are queued when driven and compared at the falling edge.
module tb_bus_rr_arbiter;
  localparam int NH = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_rr_arbiter_if #(.NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)) bus ();

  bus_rr_arbiter #(
    .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    string       name;
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic        err;
    logic [31:0] rdata;
    int          exp_sel;     // -1: no downstream request expected
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rvalid;
    logic [1:0]  exp_err;
    logic [31:0] exp_rdata;   // value expected on the rvalid host; others 0
  } vec_t;

  logic [31:0] host_addr  [NH] = '{32'h0000_0100, 32'h0000_0200};
  logic        host_we    [NH] = '{1'b0, 1'b1};
  logic [3:0]  host_be    [NH] = '{4'hF, 4'h3};
  logic [31:0] host_wdata [NH] = '{32'h1111_0000, 32'h2222_0000};

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(string n, logic [1:0] req, logic gnt, logic rv,
                              logic err, logic [31:0] rd, int sel,
                              logic [1:0] eg, logic [1:0] erv, logic [1:0] eerr,
                              logic [31:0] erd);
    vec_t v;
    v.name = n; v.req = req; v.gnt = gnt; v.rv = rv; v.err = err; v.rdata = rd;
    v.exp_sel = sel; v.exp_gnt = eg; v.exp_rvalid = erv; v.exp_err = eerr;
    v.exp_rdata = erd;
    return v;
  endfunction

  task automatic check(string what, string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  task automatic compare(vec_t v);
    logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    e_req   = (v.exp_sel >= 0);
    e_addr  = e_req ? host_addr[v.exp_sel]  : 32'h0;
    e_we    = e_req ? host_we[v.exp_sel]    : 1'b0;
    e_be    = e_req ? host_be[v.exp_sel]    : 4'h0;
    e_wdata = e_req ? host_wdata[v.exp_sel] : 32'h0;
    e_rd0   = v.exp_rvalid[0] ? v.exp_rdata : 32'h0;
    e_rd1   = v.exp_rvalid[1] ? v.exp_rdata : 32'h0;
    check(v.name, "dev_req",   64'(bus.dev_req_o),       64'(e_req));
    check(v.name, "dev_addr",  64'(bus.dev_addr_o),      64'(e_addr));
    check(v.name, "dev_we",    64'(bus.dev_we_o),        64'(e_we));
    check(v.name, "dev_be",    64'(bus.dev_be_o),        64'(e_be));
    check(v.name, "dev_wdata", 64'(bus.dev_wdata_o),     64'(e_wdata));
    check(v.name, "host_gnt",  64'(bus.host_gnt_o),      64'(v.exp_gnt));
    check(v.name, "rvalid",    64'(bus.host_rvalid_o),   64'(v.exp_rvalid));
    check(v.name, "err",       64'(bus.host_err_o),      64'(v.exp_err));
    check(v.name, "rdata0",    64'(bus.host_rdata_o[0]), 64'(e_rd0));
    check(v.name, "rdata1",    64'(bus.host_rdata_o[1]), 64'(e_rd1));
    $display("txn %-10s req=%b gnt=%b dev_req=%b addr=%h host_gnt=%b rvalid=%b err=%b rd0=%h rd1=%h",
             v.name, v.req, v.gnt, bus.dev_req_o, bus.dev_addr_o, bus.host_gnt_o,
             bus.host_rvalid_o, bus.host_err_o, bus.host_rdata_o[0], bus.host_rdata_o[1]);
  endtask

  task automatic drive(vec_t v);
    bus.host_req_i   = v.req;
    bus.dev_gnt_i    = v.gnt;
    bus.dev_rvalid_i = v.rv;
    bus.dev_err_i    = v.err;
    bus.dev_rdata_i  = v.rdata;
  endtask

  task automatic apply_vec(vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    exp_q.push_back(v);
    @(negedge clk);
    compare(exp_q.pop_front());
  endtask

  // Watchdog so the bench always ends on its own
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    vec_t zero;
    for (int h = 0; h < NH; h++) begin
      bus.host_addr_i[h]  = host_addr[h];
      bus.host_we_i[h]    = host_we[h];
      bus.host_be_i[h]    = host_be[h];
      bus.host_wdata_i[h] = host_wdata[h];
    end
    zero = mk("idle", 2'b00, 0, 0, 0, 32'h0, -1, 2'b00, 2'b00, 2'b00, 32'h0);
    drive(zero);

    //          name         req    g  rv e  rdata         sel gnt    rvld   err    exp_rdata
    vecs.push_back(mk("rst_idle",  2'b00, 0, 0, 0, 32'h0,         -1, 2'b00, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("h0_gnt",    2'b01, 1, 0, 0, 32'h0,          0, 2'b01, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("h0_resp",   2'b00, 0, 1, 0, 32'hDEADBEEF,  -1, 2'b00, 2'b01, 2'b00, 32'hDEADBEEF));
    vecs.push_back(mk("rr_g1",     2'b11, 1, 0, 0, 32'h0,          1, 2'b10, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("rr_r1",     2'b11, 0, 1, 0, 32'hA1A1A1A1,  -1, 2'b00, 2'b10, 2'b00, 32'hA1A1A1A1));
    vecs.push_back(mk("rr_g0",     2'b11, 1, 0, 0, 32'h0,          0, 2'b01, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("rr_r0",     2'b11, 0, 1, 0, 32'hA2A2A2A2,  -1, 2'b00, 2'b01, 2'b00, 32'hA2A2A2A2));
    vecs.push_back(mk("rr_g1b",    2'b11, 1, 0, 0, 32'h0,          1, 2'b10, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("rr_r1err",  2'b11, 0, 1, 1, 32'hA3A3A3A3,  -1, 2'b00, 2'b10, 2'b10, 32'hA3A3A3A3));
    vecs.push_back(mk("lock_c0",   2'b10, 0, 0, 0, 32'h0,          1, 2'b00, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("lock_c1",   2'b11, 0, 0, 0, 32'h0,          1, 2'b00, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("lock_c2",   2'b11, 0, 0, 0, 32'h0,          1, 2'b00, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("lock_gnt",  2'b11, 1, 0, 0, 32'h0,          1, 2'b10, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("lock_resp", 2'b01, 0, 1, 0, 32'hB1B1B1B1,  -1, 2'b00, 2'b10, 2'b00, 32'hB1B1B1B1));
    vecs.push_back(mk("tmo_gnt",   2'b01, 1, 0, 0, 32'h0,          0, 2'b01, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("tmo_w1",    2'b00, 0, 0, 0, 32'h0,         -1, 2'b00, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("tmo_w2",    2'b00, 0, 0, 0, 32'h0,         -1, 2'b00, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("tmo_w3",    2'b00, 0, 0, 0, 32'h0,         -1, 2'b00, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("tmo_fire",  2'b00, 0, 0, 0, 32'h55555555,  -1, 2'b00, 2'b01, 2'b01, 32'h0));
    vecs.push_back(mk("tmo_after", 2'b00, 0, 0, 0, 32'h0,         -1, 2'b00, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("stale_rv",  2'b00, 0, 1, 1, 32'hC1C1C1C1,  -1, 2'b00, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("sim_gnt",   2'b10, 1, 0, 0, 32'h0,          1, 2'b10, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("sim_w1",    2'b00, 0, 0, 0, 32'h0,         -1, 2'b00, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("sim_w2",    2'b00, 0, 0, 0, 32'h0,         -1, 2'b00, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("sim_w3",    2'b00, 0, 0, 0, 32'h0,         -1, 2'b00, 2'b00, 2'b00, 32'h0));
    vecs.push_back(mk("sim_resp",  2'b00, 0, 1, 0, 32'hD1D1D1D1,  -1, 2'b00, 2'b10, 2'b00, 32'hD1D1D1D1));
    vecs.push_back(mk("pre_rst_g", 2'b01, 1, 0, 0, 32'h0,          0, 2'b01, 2'b00, 2'b00, 32'h0));

    // Outputs while held in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(mk("in_reset", 2'b00, 0, 0, 0, 32'h0, -1, 2'b00, 2'b00, 2'b00, 32'h0));
    compare(exp_q.pop_front());
    rst_n = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Reset pulse while host0's transaction is outstanding
    @(posedge clk);
    #1;
    drive(zero);
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(mk("rst_pulse", 2'b00, 0, 0, 0, 32'h0, -1, 2'b00, 2'b00, 2'b00, 32'h0));
    compare(exp_q.pop_front());
    @(negedge clk);
    #1 rst_n = 1'b1;

    apply_vec(mk("post_stale", 2'b00, 0, 1, 0, 32'hE1E1E1E1, -1, 2'b00, 2'b00, 2'b00, 32'h0));
    apply_vec(mk("post_g0",    2'b11, 1, 0, 0, 32'h0,         0, 2'b01, 2'b00, 2'b00, 32'h0));
    apply_vec(mk("post_r0",    2'b00, 0, 1, 0, 32'hE2E2E2E2, -1, 2'b00, 2'b01, 2'b00, 32'hE2E2E2E2));
    apply_vec(mk("post_g1",    2'b10, 1, 0, 0, 32'h0,         1, 2'b10, 2'b00, 2'b00, 32'h0));
    apply_vec(mk("post_r1",    2'b00, 0, 1, 0, 32'hE3E3E3E3, -1, 2'b00, 2'b10, 2'b00, 32'hE3E3E3E3));
    apply_vec(zero);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
